// File: rtl/vit_frame_sequencer.sv
// Streams softbit words into the decoder input buffer, then starts a frame and waits for done; buffer writes appear 1 cycle after the handshake.
// Backpressure: s_ready_o is only high in LOAD, so the stream stalls while a frame is gapped, started or decoded.
module vit_frame_sequencer #(
  parameter int SRC_ADDR_W = 12,
  parameter int DATA_W     = 24,
  parameter int FRM_W      = 8,
  parameter int TO_W       = 16,
  parameter int GAP_CYC    = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_an_i,
  input  logic                  start_i,
  input  logic [FRM_W-1:0]      num_frames_i,
  input  logic [SRC_ADDR_W-1:0] frame_len_i,
  input  logic [SRC_ADDR_W-1:0] src_base_addr_i,
  input  logic [TO_W-1:0]       timeout_i,
  input  logic                  s_valid_i,
  input  logic [DATA_W-1:0]     s_data_i,
  output logic                  s_ready_o,
  output logic                  buf_wr_o,
  output logic [SRC_ADDR_W-1:0] buf_addr_o,
  output logic [DATA_W-1:0]     buf_wdata_o,
  output logic                  frame_start_o,
  input  logic                  frame_done_i,
  input  logic                  dst_wr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic [FRM_W-1:0]      frame_cnt_o,
  output logic [15:0]           out_wr_cnt_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_START, S_WAIT, S_ERR} state_t;

  localparam logic [7:0]            GAP_LAST = 8'(GAP_CYC - 1);
  localparam logic [SRC_ADDR_W-1:0] ONE_A    = SRC_ADDR_W'(1);
  localparam logic [FRM_W-1:0]      ONE_F    = FRM_W'(1);
  localparam logic [TO_W-1:0]       ONE_T    = TO_W'(1);

  state_t                state_q, state_d;
  logic [FRM_W-1:0]      nfrm_q, nfrm_d;
  logic [SRC_ADDR_W-1:0] flen_q, flen_d;
  logic [SRC_ADDR_W-1:0] base_q, base_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic [SRC_ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]            gap_q, gap_d;
  logic [TO_W-1:0]       tcnt_q, tcnt_d;
  logic [FRM_W-1:0]      fcnt_q, fcnt_d;
  logic [15:0]           owc_q, owc_d;
  logic                  tout_q, tout_d;
  logic                  done_q, done_d;
  logic                  wr_q, wr_d;
  logic [SRC_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  fstart_q, fstart_d;

  logic                  busy;
  logic                  hs;
  logic [SRC_ADDR_W-1:0] idx_inc;
  logic [FRM_W-1:0]      fcnt_inc;
  logic [TO_W-1:0]       tcnt_inc;

  assign busy     = (state_q == S_LOAD) || (state_q == S_GAP) ||
                    (state_q == S_START) || (state_q == S_WAIT);
  // A zero-length frame must never accept a word, so ready is gated on the length.
  assign s_ready_o = (state_q == S_LOAD) && (flen_q != '0);
  assign hs        = s_valid_i && s_ready_o;
  assign idx_inc   = idx_q + ONE_A;
  assign fcnt_inc  = fcnt_q + ONE_F;
  assign tcnt_inc  = tcnt_q + ONE_T;

  always_comb begin
    state_d  = state_q;
    nfrm_d   = nfrm_q;
    flen_d   = flen_q;
    base_d   = base_q;
    to_d     = to_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    tcnt_d   = tcnt_q;
    fcnt_d   = fcnt_q;
    owc_d    = owc_q;
    tout_d   = tout_q;
    done_d   = 1'b0;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    fstart_d = 1'b0;

    if (busy && dst_wr_i && (owc_q != 16'hFFFF)) begin
      owc_d = owc_q + 16'd1;
    end

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start_i) begin
          nfrm_d = num_frames_i;
          flen_d = frame_len_i;
          base_d = src_base_addr_i;
          to_d   = timeout_i;
          fcnt_d = '0;
          owc_d  = '0;
          tout_d = 1'b0;
          idx_d  = '0;
          gap_d  = '0;
          tcnt_d = '0;
          if (num_frames_i == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (flen_q == '0) begin
          state_d = S_GAP;
        end else if (hs) begin
          wr_d    = 1'b1;
          addr_d  = base_q + idx_q;
          wdata_d = s_data_i;
          if (idx_inc == flen_q) begin
            idx_d   = '0;
            state_d = S_GAP;
          end else begin
            idx_d = idx_inc;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_START;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_START: begin
        fstart_d = 1'b1;
        tcnt_d   = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        tcnt_d = tcnt_inc;
        // frame_done_i is checked first so it wins over a coincident timeout.
        if (frame_done_i) begin
          fcnt_d = fcnt_inc;
          tcnt_d = '0;
          if (fcnt_inc == nfrm_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end else if ((to_q != '0) && (tcnt_inc == to_q)) begin
          tout_d  = 1'b1;
          tcnt_d  = '0;
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      state_q  <= S_IDLE;
      nfrm_q   <= '0;
      flen_q   <= '0;
      base_q   <= '0;
      to_q     <= '0;
      idx_q    <= '0;
      gap_q    <= '0;
      tcnt_q   <= '0;
      fcnt_q   <= '0;
      owc_q    <= '0;
      tout_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      fstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      nfrm_q   <= nfrm_d;
      flen_q   <= flen_d;
      base_q   <= base_d;
      to_q     <= to_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      tcnt_q   <= tcnt_d;
      fcnt_q   <= fcnt_d;
      owc_q    <= owc_d;
      tout_q   <= tout_d;
      done_q   <= done_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      fstart_q <= fstart_d;
    end
  end

  assign buf_wr_o      = wr_q;
  assign buf_addr_o    = addr_q;
  assign buf_wdata_o   = wdata_q;
  assign frame_start_o = fstart_q;
  assign busy_o        = busy;
  assign done_o        = done_q;
  assign timeout_o     = tout_q;
  assign frame_cnt_o   = fcnt_q;
  assign out_wr_cnt_o  = owc_q;

endmodule

// File: doc/vit_frame_sequencer.md
VIT_FRAME_SEQUENCER -- requirements
Module: vit_frame_sequencer

Interface
REQ-001 Parameter SRC_ADDR_W, default 12, input-buffer address width.
REQ-002 Parameter DATA_W, default 24, softbit word width.
REQ-003 Parameter FRM_W, default 8, frame-count width.
REQ-004 Parameter TO_W, default 16, timeout-counter width.
REQ-005 Parameter GAP_CYC, default 10, idle cycles between end of load and frame_start_o; range 1 to 255.
REQ-006 Ports, in order (name, direction, width, meaning):
- clk_i  in  1  single clock, all logic on rising edge.
- rst_an_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  run-start pulse.
- num_frames_i  in  FRM_W  frames per run.
- frame_len_i  in  SRC_ADDR_W  words per frame.
- src_base_addr_i  in  SRC_ADDR_W  first buffer address.
- timeout_i  in  TO_W  max cycles waiting for frame_done_i; 0 disables the timeout.
- s_valid_i  in  1  softbit stream valid.
- s_data_i  in  DATA_W  softbit stream data.
- s_ready_o  out  1  softbit stream ready.
- buf_wr_o  out  1  input-buffer write enable.
- buf_addr_o  out  SRC_ADDR_W  input-buffer write address.
- buf_wdata_o  out  DATA_W  input-buffer write data.
- frame_start_o  out  1  decoder frame-start pulse.
- frame_done_i  in  1  decoder frame-done pulse.
- dst_wr_i  in  1  decoder output-write monitor.
- busy_o  out  1  run in progress.
- done_o  out  1  run-complete pulse.
- timeout_o  out  1  sticky timeout error.
- frame_cnt_o  out  FRM_W  frames completed in the current run.
- out_wr_cnt_o  out  16  dst_wr_i pulses counted in the current run.

Function
REQ-007 FSM states: IDLE, LOAD, GAP, START, WAIT, ERR.
REQ-008 IDLE:
- start_i=1 latches num_frames_i, frame_len_i, src_base_addr_i and timeout_i.
- Clears frame_cnt_o, out_wr_cnt_o and timeout_o.
- Next state is LOAD; if num_frames_i=0, next state is IDLE with done_o=1 for 1 cycle.
REQ-009 start_i is ignored in every state except IDLE and ERR.
REQ-010 LOAD: s_ready_o=1; it is 0 in all other states.
REQ-011 Each s_valid_i&s_ready_o handshake causes, on the next cycle:
- buf_wr_o=1 for exactly 1 cycle;
- buf_wdata_o = the accepted data;
- buf_addr_o = (base + word index) mod 2^SRC_ADDR_W, so the address wraps silently.
REQ-012 The word index restarts at 0 for every frame, so each frame overwrites the same buffer region.
REQ-013 LOAD goes to GAP in the cycle of the frame_len-th handshake; frame_len=0 goes straight from LOAD to GAP.
REQ-014 GAP lasts exactly GAP_CYC cycles, then the FSM enters START.
REQ-015 START: frame_start_o=1 for exactly 1 cycle, then the FSM enters WAIT.
REQ-016 WAIT: a timeout counter increments every cycle.
- frame_done_i=1 increments frame_cnt_o (1 cycle later).
- If the incremented count equals num_frames, done_o=1 for 1 cycle and the FSM enters IDLE; otherwise it enters LOAD.
REQ-017 WAIT timeout: when timeout≠0 and the counter reaches timeout without frame_done_i, timeout_o is set and the FSM enters ERR.
REQ-018 If frame_done_i and the timeout condition occur in the same cycle, frame_done_i wins and no error is raised.
REQ-019 frame_done_i outside WAIT is ignored.
REQ-020 ERR: timeout_o stays 1, busy_o=0, no writes; start_i restarts the run as from IDLE.
REQ-021 out_wr_cnt_o increments on every dst_wr_i while busy_o=1 and saturates at 16'hFFFF.
REQ-022 busy_o=1 in LOAD, GAP, START and WAIT; 0 otherwise.
REQ-023 frame_cnt_o does not wrap; num_frames bounds it.

Reset
REQ-024 rst_an_i low asynchronously forces the FSM to IDLE and all outputs and counters to 0, mid-run included.
REQ-025 On rst_an_i release, no buf_wr_o or frame_start_o pulse is produced until a new start_i.

Verification
REQ-026 num_frames=2, frame_len=0x68, base=0, s_valid_i held high -> per frame, 0x68 writes to addresses 0..0x67 with data in stream order; frame_start_o asserted GAP_CYC+1 cycles after the last write; done_o after the 2nd frame_done_i; frame_cnt_o=2.
REQ-027 base=0xFF0, frame_len=0x20 -> addresses 0xFF0..0xFFF, then 0x000..0x00F.
REQ-028 timeout=50, frame_done_i never asserted -> timeout_o=1 exactly 50 cycles into WAIT; FSM in ERR; busy_o=0; a following start_i clears timeout_o.
REQ-029 s_valid_i toggling every other cycle -> write count and order unchanged; no write without a preceding handshake.
REQ-030 rst_an_i pulsed low during LOAD after 10 writes -> all outputs 0 immediately; after release, no activity until start_i.
REQ-031 frame_done_i on the timeout cycle -> frame counted; timeout_o stays 0.
